// File: rtl/ifetch_unit.sv
// Instruction-fetch initiator: issues sequential PCs to imem under a credit limit,
// buffers returned instructions in program order and discards stale responses after a redirect.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FBUF_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    output logic        imem_resp_ready,
    input  logic [31:0] imem_resp_inst,
    output logic        fetch_valid,
    input  logic        fetch_ready,
    output logic [31:0] fetch_pc,
    output logic [31:0] fetch_inst
);

    localparam int IW = $clog2(FBUF_DEPTH);
    localparam int PW = IW + 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FBUF_DEPTH);
    localparam logic [PW-1:0] ONE     = PW'(1);

    logic [31:0]   pc_q, pc_d;
    logic [PW-1:0] alloc_q, alloc_d;
    logic [PW-1:0] fill_q, fill_d;
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] drop_q, drop_d;
    logic [31:0]   pc_mem_q   [FBUF_DEPTH];
    logic [31:0]   inst_mem_q [FBUF_DEPTH];

    logic [PW-1:0] occ;
    logic [PW-1:0] unfilled;
    logic [CW-1:0] credits_used;
    logic [31:0]   redirect_base;
    logic          issue_fire;
    logic          resp_fire;
    logic          resp_drop;
    logic          resp_fill;
    logic          fetch_fire;

    // Stale in-flight responses still hold a credit until they come back and are dropped.
    assign occ          = alloc_q - head_q;
    assign unfilled     = alloc_q - fill_q;
    assign credits_used = {1'b0, occ} + {1'b0, drop_q};
    assign redirect_base = redirect_pc & 32'hFFFF_FFFC;

    assign imem_req_valid  = (credits_used < DEPTH_C) && !redirect_valid && !rst;
    assign imem_req_addr   = pc_q;
    assign imem_resp_ready = 1'b1;

    assign fetch_valid = (head_q != fill_q) && !redirect_valid;
    assign fetch_pc    = pc_mem_q[head_q[IW-1:0]];
    assign fetch_inst  = inst_mem_q[head_q[IW-1:0]];

    assign issue_fire = imem_req_valid && imem_req_ready;
    assign resp_fire  = imem_resp_valid;
    assign resp_drop  = resp_fire && (drop_q != '0);
    assign resp_fill  = resp_fire && (drop_q == '0) && !redirect_valid;
    assign fetch_fire = fetch_valid && fetch_ready;

    always_comb begin
        pc_d    = pc_q;
        alloc_d = alloc_q;
        fill_d  = fill_q;
        head_d  = head_q;
        drop_d  = drop_q;
        if (redirect_valid) begin
            // Every request not yet answered becomes stale, minus one if it answers right now.
            pc_d   = redirect_base;
            drop_d = drop_q + unfilled - {{(PW-1){1'b0}}, resp_fire};
            head_d = alloc_q;
            fill_d = alloc_q;
        end else begin
            if (issue_fire) begin
                alloc_d = alloc_q + ONE;
                pc_d    = pc_q + 32'd4;
            end
            if (resp_drop) begin
                drop_d = drop_q - ONE;
            end
            if (resp_fill) begin
                fill_d = fill_q + ONE;
            end
            if (fetch_fire) begin
                head_d = head_q + ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            alloc_q <= '0;
            fill_q  <= '0;
            head_q  <= '0;
            drop_q  <= '0;
        end else begin
            pc_q    <= pc_d;
            alloc_q <= alloc_d;
            fill_q  <= fill_d;
            head_q  <= head_d;
            drop_q  <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FBUF_DEPTH; i++) begin
                pc_mem_q[i]   <= '0;
                inst_mem_q[i] <= '0;
            end
        end else begin
            if (issue_fire) begin
                pc_mem_q[alloc_q[IW-1:0]] <= pc_q;
            end
            if (resp_fill) begin
                inst_mem_q[fill_q[IW-1:0]] <= imem_resp_inst;
            end
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: a scripted vector table plus an imem/decode environment
// checked every cycle against a queue-based model of requests, buffer and deliveries.
module tb_ifetch_unit;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        redirectValid;
    logic [31:0] redirectPc;
    logic        imemReqValid;
    logic        imemReqReady;
    logic [31:0] imemReqAddr;
    logic        imemRespValid;
    logic        imemRespReady;
    logic [31:0] imemRespInst;
    logic        fetchValid;
    logic        fetchReady;
    logic [31:0] fetchPc;
    logic [31:0] fetchInst;

    int assertCount = 0;
    int failCount   = 0;

    ifetch_unit #(.RESET_PC(32'h0000_0000), .FBUF_DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .redirect_valid  (redirectValid),
        .redirect_pc     (redirectPc),
        .imem_req_valid  (imemReqValid),
        .imem_req_ready  (imemReqReady),
        .imem_req_addr   (imemReqAddr),
        .imem_resp_valid (imemRespValid),
        .imem_resp_ready (imemRespReady),
        .imem_resp_inst  (imemRespInst),
        .fetch_valid     (fetchValid),
        .fetch_ready     (fetchReady),
        .fetch_pc        (fetchPc),
        .fetch_inst      (fetchInst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        redir;
        logic [31:0] redirPc;
        logic        reqReady;
        logic        respValid;
        logic [31:0] respInst;
        logic        fetchReady;
        logic        expReq;
        logic [31:0] expAddr;
        logic        expFv;
        logic [31:0] expPc;
        logic [31:0] expInst;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } req_t;

    vec_t        vecs[$];
    req_t        imemQ[$];
    logic [31:0] bufQ[$];
    logic [31:0] deliveredLog[$];
    logic [31:0] mdlIssuePc;
    int          cycleNum;
    int          lat;
    int          readyPct;
    int          fetchPct;
    int          respPct;

    function automatic logic [31:0] memInst(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic vec_t mk(input logic r, input logic rd, input logic [31:0] rpc,
                                input logic rr, input logic rv, input logic [31:0] ri,
                                input logic fr, input logic er, input logic [31:0] ea,
                                input logic ef, input logic [31:0] ep, input logic [31:0] ei);
        vec_t v;
        v.rst = r; v.redir = rd; v.redirPc = rpc; v.reqReady = rr;
        v.respValid = rv; v.respInst = ri; v.fetchReady = fr;
        v.expReq = er; v.expAddr = ea; v.expFv = ef; v.expPc = ep; v.expInst = ei;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        rst           = v.rst;
        redirectValid = v.redir;
        redirectPc    = v.redirPc;
        imemReqReady  = v.reqReady;
        imemRespValid = v.respValid;
        imemRespInst  = v.respInst;
        fetchReady    = v.fetchReady;
    endtask

    // Holds reset for two edges, checks reset-state outputs, releases it just after an edge.
    task automatic doReset();
        @(negedge clk);
        rst = 1'b1; redirectValid = 1'b0; redirectPc = '0; imemReqReady = 1'b0;
        imemRespValid = 1'b0; imemRespInst = '0; fetchReady = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        checkOutput("rst_req_valid", {31'b0, imemReqValid}, 32'd0);
        checkOutput("rst_fetch_valid", {31'b0, fetchValid}, 32'd0);
        checkOutput("rst_resp_ready", {31'b0, imemRespReady}, 32'd1);
        checkOutput("rst_fetch_pc", fetchPc, 32'd0);
        checkOutput("rst_fetch_inst", fetchInst, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        imemQ.delete();
        bufQ.delete();
        deliveredLog.delete();
        mdlIssuePc = 32'h0000_0000;
        cycleNum = 0;
    endtask

    // One cycle of environment: imem answers in order after `lat` cycles, decode accepts randomly.
    task automatic engineCycle(input bit doRedir, input logic [31:0] tgt);
        bit   expReq, expFv, issue, ffire, rfire;
        req_t e;
        e.addr = '0; e.due = 0; e.stale = 1'b0;
        @(negedge clk);
        redirectValid = doRedir;
        redirectPc    = tgt;
        imemReqReady  = ($urandom_range(99, 0) < readyPct);
        fetchReady    = ($urandom_range(99, 0) < fetchPct);
        rfire = (imemQ.size() > 0) && (imemQ[0].due <= cycleNum) && ($urandom_range(99, 0) < respPct);
        imemRespValid = rfire;
        imemRespInst  = rfire ? memInst(imemQ[0].addr) : $urandom;
        #1;
        expReq = !doRedir && ((imemQ.size() + bufQ.size()) < DEPTH);
        expFv  = !doRedir && (bufQ.size() > 0);
        checkOutput("req_valid", {31'b0, imemReqValid}, {31'b0, expReq});
        if (expReq) checkOutput("req_addr", imemReqAddr, mdlIssuePc);
        checkOutput("fetch_valid", {31'b0, fetchValid}, {31'b0, expFv});
        if (expFv) begin
            checkOutput("fetch_pc", fetchPc, bufQ[0]);
            checkOutput("fetch_inst", fetchInst, memInst(bufQ[0]));
        end
        issue = expReq && imemReqReady;
        ffire = expFv && fetchReady;
        if (rfire) e = imemQ.pop_front();
        if (doRedir) begin
            bufQ.delete();
            foreach (imemQ[i]) imemQ[i].stale = 1'b1;
            mdlIssuePc = tgt & 32'hFFFF_FFFC;
        end else begin
            if (ffire) deliveredLog.push_back(bufQ.pop_front());
            if (rfire && !e.stale) bufQ.push_back(e.addr);
            if (issue) begin
                imemQ.push_back('{mdlIssuePc, cycleNum + lat, 1'b0});
                mdlIssuePc = mdlIssuePc + 32'd4;
            end
        end
        @(posedge clk);
        cycleNum++;
    endtask

    task automatic setEnv(input int l, input int rdy, input int fch, input int rsp);
        lat = l; readyPct = rdy; fetchPct = fch; respPct = rsp;
    endtask

    task automatic checkFirst(input string name, input logic [31:0] exp);
        checkOutput(name, (deliveredLog.size() > 0) ? deliveredLog[0] : 32'hFFFF_FFFF, exp);
    endtask

    initial begin
        rst = 1'b1; redirectValid = 1'b0; redirectPc = '0; imemReqReady = 1'b0;
        imemRespValid = 1'b0; imemRespInst = '0; fetchReady = 1'b0;
        setEnv(1, 100, 100, 100);

        // Scripted run: fill to the credit cap with decode stalled, drain, redirect, mid-run reset.
        vecs.push_back(mk(0,0,0, 1,0,0,            0, 1,32'h0,   0,0,0));
        vecs.push_back(mk(0,0,0, 1,1,32'hC0DE_0000, 0, 1,32'h4,   0,0,0));
        vecs.push_back(mk(0,0,0, 1,1,32'hC0DE_0001, 0, 1,32'h8,   1,32'h0,32'hC0DE_0000));
        vecs.push_back(mk(0,0,0, 1,1,32'hC0DE_0002, 0, 1,32'hC,   1,32'h0,32'hC0DE_0000));
        vecs.push_back(mk(0,0,0, 1,1,32'hC0DE_0003, 0, 0,32'h10,  1,32'h0,32'hC0DE_0000));
        vecs.push_back(mk(0,0,0, 1,0,0,             1, 0,32'h10,  1,32'h0,32'hC0DE_0000));
        vecs.push_back(mk(0,0,0, 1,0,0,             0, 1,32'h10,  1,32'h4,32'hC0DE_0001));
        vecs.push_back(mk(0,0,0, 1,1,32'hC0DE_0004, 0, 0,32'h14,  1,32'h4,32'hC0DE_0001));
        vecs.push_back(mk(0,0,0, 1,0,0,             1, 0,32'h14,  1,32'h4,32'hC0DE_0001));
        vecs.push_back(mk(0,0,0, 1,0,0,             1, 1,32'h14,  1,32'h8,32'hC0DE_0002));
        vecs.push_back(mk(0,0,0, 1,1,32'hC0DE_0005, 1, 1,32'h18,  1,32'hC,32'hC0DE_0003));
        vecs.push_back(mk(0,1,32'h103, 1,0,0,       1, 0,32'h0,   0,0,0));
        vecs.push_back(mk(0,0,0, 1,1,32'hDEAD_BEEF, 1, 1,32'h100, 0,0,0));
        vecs.push_back(mk(0,0,0, 1,1,32'hC0DE_0006, 1, 1,32'h104, 0,0,0));
        vecs.push_back(mk(0,0,0, 1,0,0,             1, 1,32'h108, 1,32'h100,32'hC0DE_0006));
        vecs.push_back(mk(1,0,0, 1,0,0,             1, 0,32'h0,   0,0,0));
        vecs.push_back(mk(0,0,0, 1,0,0,             1, 1,32'h0,   0,0,0));

        doReset();
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("vec%0d_req_valid", i), {31'b0, imemReqValid}, {31'b0, vecs[i].expReq});
            if (vecs[i].expReq)
                checkOutput($sformatf("vec%0d_req_addr", i), imemReqAddr, vecs[i].expAddr);
            checkOutput($sformatf("vec%0d_fetch_valid", i), {31'b0, fetchValid}, {31'b0, vecs[i].expFv});
            if (vecs[i].expFv) begin
                checkOutput($sformatf("vec%0d_fetch_pc", i), fetchPc, vecs[i].expPc);
                checkOutput($sformatf("vec%0d_fetch_inst", i), fetchInst, vecs[i].expInst);
            end
            checkOutput($sformatf("vec%0d_resp_ready", i), {31'b0, imemRespReady}, 32'd1);
        end

        // Sustained streaming with a 1-cycle imem: one delivery per cycle after two cycles of fill.
        doReset();
        setEnv(1, 100, 100, 100);
        for (int i = 0; i < 20; i++) engineCycle(1'b0, '0);
        checkOutput("stream_count", deliveredLog.size(), 32'd18);
        checkFirst("stream_first_pc", 32'h0);

        // Three requests in flight, then redirect: all three answers must be dropped.
        doReset();
        setEnv(4, 100, 100, 100);
        for (int i = 0; i < 3; i++) engineCycle(1'b0, '0);
        engineCycle(1'b1, 32'h100);
        for (int i = 0; i < 16; i++) engineCycle(1'b0, '0);
        checkFirst("redir3_first_pc", 32'h100);

        // Redirect coincides with a response while two are unfilled: only one later answer is stale.
        doReset();
        setEnv(2, 100, 100, 100);
        for (int i = 0; i < 2; i++) engineCycle(1'b0, '0);
        readyPct = 0;
        engineCycle(1'b1, 32'h40);
        readyPct = 100;
        for (int i = 0; i < 12; i++) engineCycle(1'b0, '0);
        checkFirst("redir_resp_first_pc", 32'h40);

        // Two redirects two cycles apart on a slow imem: nothing from the first target appears.
        doReset();
        setEnv(4, 100, 100, 100);
        for (int i = 0; i < 6; i++) engineCycle(1'b0, '0);
        deliveredLog.delete();
        engineCycle(1'b1, 32'h200);
        engineCycle(1'b0, '0);
        engineCycle(1'b1, 32'h300);
        for (int i = 0; i < 25; i++) engineCycle(1'b0, '0);
        checkFirst("double_redir_first_pc", 32'h300);

        // Random handshakes, response gaps and occasional redirects.
        doReset();
        setEnv(2, 60, 60, 70);
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(99, 0) < 2) engineCycle(1'b1, $urandom);
            else engineCycle(1'b0, '0);
        end
        checkOutput("random_progress", {31'b0, deliveredLog.size() > 30}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
